// File: rtl/pc_stack_unit_if.sv
// Command/status bundle between the control unit (master) and the PC/RAS block (slave).
// Commands are level-sampled on each rising clock edge; all status signals are registered in the slave.
interface pc_stack_unit_if #(
  parameter int W     = 16,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic           ld;
  logic           inc;
  logic           rel;
  logic           call;
  logic           ret;
  logic           clr_err;
  logic [W-1:0]   in;
  logic [W-1:0]   off;
  logic [W-1:0]   out;
  logic [W-1:0]   ra_top;
  logic [SPW-1:0] sp_cnt;
  logic           empty;
  logic           full;
  logic           err;

  modport master (
    output ld, inc, rel, call, ret, clr_err, in, off,
    input  out, ra_top, sp_cnt, empty, full, err
  );

  modport slave (
    input  ld, inc, rel, call, ret, clr_err, in, off,
    output out, ra_top, sp_cnt, empty, full, err
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with relative jump and return-address stack; priority ret > call > ld > rel > inc.
// Latency: one cycle, every output registered; no backpressure, stack faults set a sticky err.
module pc_stack_unit #(
  parameter int          W       = 16,
  parameter int          DEPTH   = 8,
  parameter int          STEP    = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  pc_stack_unit_if.slave   bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   ra_top_q, ra_top_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           empty_q, empty_d;
  logic           full_q, full_d;
  logic           err_q, err_d;
  logic [W-1:0]   stack_q [DEPTH];
  logic [W-1:0]   stack_d [DEPTH];

  logic [W-1:0]   ret_addr;
  logic [SPW-1:0] below_sp;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  below_idx;

  assign ret_addr  = pc_q + W'(STEP);
  assign below_sp  = sp_q - SPW'(2);
  assign push_idx  = sp_q[IW-1:0];
  assign below_idx = below_sp[IW-1:0];

  always_comb begin
    pc_d     = pc_q;
    ra_top_d = ra_top_q;
    sp_d     = sp_q;
    stack_d  = stack_q;
    // clear first so a fault in the same cycle overrides it
    err_d    = bus.clr_err ? 1'b0 : err_q;

    if (bus.ret) begin
      if (sp_q == '0) begin
        err_d = 1'b1;
      end else begin
        pc_d     = ra_top_q;
        sp_d     = sp_q - SPW'(1);
        ra_top_d = (sp_q >= SPW'(2)) ? stack_q[below_idx] : '0;
      end
    end else if (bus.call) begin
      if (sp_q == SPW'(DEPTH)) begin
        err_d = 1'b1;
      end else begin
        pc_d              = bus.in;
        stack_d[push_idx] = ret_addr;
        sp_d              = sp_q + SPW'(1);
        ra_top_d          = ret_addr;
      end
    end else if (bus.ld) begin
      pc_d = bus.in;
    end else if (bus.rel) begin
      pc_d = pc_q + bus.off;
    end else if (bus.inc) begin
      pc_d = ret_addr;
    end

    empty_d = (sp_d == '0);
    full_d  = (sp_d == SPW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc_q     <= RST_VAL;
      ra_top_q <= '0;
      sp_q     <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ra_top_q <= ra_top_d;
      sp_q     <= sp_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  // stack contents are don't-care after reset, so no reset branch
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.out    = pc_q;
  assign bus.ra_top = ra_top_q;
  assign bus.sp_cnt = sp_q;
  assign bus.empty  = empty_q;
  assign bus.full   = full_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed-vector bench for pc_stack_unit (W=16, DEPTH=8, STEP=1, RST_VAL=0).
module tb_pc_stack_unit;
  localparam logic [5:0] C_RET = 6'b100000;
  localparam logic [5:0] C_CAL = 6'b010000;
  localparam logic [5:0] C_LD  = 6'b001000;
  localparam logic [5:0] C_REL = 6'b000100;
  localparam logic [5:0] C_INC = 6'b000010;
  localparam logic [5:0] C_CLR = 6'b000001;

  logic clk;
  logic rst_b;
  int   passed;
  int   total;

  pc_stack_unit_if #(.W(16), .DEPTH(8)) bus ();

  pc_stack_unit #(.W(16), .DEPTH(8), .STEP(1), .RST_VAL(16'h0000)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.ret = 0; bus.call = 0; bus.ld = 0; bus.rel = 0; bus.inc = 0; bus.clr_err = 0;
  endtask

  // Apply one command vector for one edge, then sample 1 time unit after the edge.
  task automatic do_cmd(input logic [5:0] c, input logic [15:0] a, input logic [15:0] o);
    {bus.ret, bus.call, bus.ld, bus.rel, bus.inc, bus.clr_err} = c;
    bus.in  = a;
    bus.off = o;
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    drive_idle();
    bus.in = '0; bus.off = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out !== 16'h0000) $display("FAIL rst_out got %h want 0000", bus.out); else passed++;
    total++; if (bus.sp_cnt !== 4'd0) $display("FAIL rst_sp got %0d want 0", bus.sp_cnt); else passed++;
    total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) $display("FAIL rst_flags got e=%b f=%b want e=1 f=0", bus.empty, bus.full); else passed++;
    total++; if (bus.err !== 1'b0 || bus.ra_top !== 16'h0000) $display("FAIL rst_err_ra got err=%b ra=%h want 0 0000", bus.err, bus.ra_top); else passed++;
    @(negedge clk);
    rst_b = 1'b1;
    // build a partial stack, then reset mid-cycle
    do_cmd(C_CAL, 16'h0040, 0);
    do_cmd(C_CAL, 16'h0050, 0);
    do_cmd(C_RET, 0, 0);
    do_cmd(C_RET, 0, 0);
    do_cmd(C_RET, 0, 0);
    do_cmd(C_CAL, 16'h0011, 0);
    do_cmd(C_CAL, 16'h0022, 0);
    do_cmd(C_CAL, 16'h0033, 0);
    total++; if (bus.sp_cnt !== 4'd3 || bus.err !== 1'b1) $display("FAIL pre_rst got sp=%0d err=%b want 3 1", bus.sp_cnt, bus.err); else passed++;
    #2;
    rst_b = 1'b0;
    #1;
    total++; if (bus.out !== 16'h0000 || bus.sp_cnt !== 4'd0) $display("FAIL async_rst got out=%h sp=%0d want 0000 0", bus.out, bus.sp_cnt); else passed++;
    total++; if (bus.empty !== 1'b1 || bus.err !== 1'b0 || bus.ra_top !== 16'h0000) $display("FAIL async_rst_flags got e=%b err=%b ra=%h want 1 0 0000", bus.empty, bus.err, bus.ra_top); else passed++;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_load_inc();
    do_cmd(C_LD, 16'h1234, 0);
    total++; if (bus.out !== 16'h1234) $display("FAIL ld got %h want 1234", bus.out); else passed++;
    do_cmd(C_INC, 0, 0);
    total++; if (bus.out !== 16'h1235) $display("FAIL inc1 got %h want 1235", bus.out); else passed++;
    do_cmd(C_INC, 0, 0);
    total++; if (bus.out !== 16'h1236) $display("FAIL inc2 got %h want 1236", bus.out); else passed++;
    do_cmd(6'b000000, 16'h9999, 0);
    total++; if (bus.out !== 16'h1236) $display("FAIL hold got %h want 1236", bus.out); else passed++;
    do_cmd(C_LD, 16'hFFFF, 0);
    do_cmd(C_INC, 0, 0);
    total++; if (bus.out !== 16'h0000) $display("FAIL inc_wrap got %h want 0000", bus.out); else passed++;
  endtask

  task automatic test_rel();
    do_cmd(C_LD, 16'h0010, 0);
    do_cmd(C_REL, 0, 16'hFFF8);
    total++; if (bus.out !== 16'h0008) $display("FAIL rel_neg got %h want 0008", bus.out); else passed++;
    do_cmd(C_REL, 0, 16'h0004);
    total++; if (bus.out !== 16'h000C) $display("FAIL rel_pos got %h want 000c", bus.out); else passed++;
    do_cmd(C_LD, 16'h0002, 0);
    do_cmd(C_REL, 0, 16'hFFFC);
    total++; if (bus.out !== 16'hFFFE) $display("FAIL rel_wrap got %h want fffe", bus.out); else passed++;
  endtask

  task automatic test_call_ret();
    do_cmd(C_LD, 16'h0100, 0);
    do_cmd(C_CAL, 16'h0200, 0);
    total++; if (bus.out !== 16'h0200 || bus.ra_top !== 16'h0101 || bus.sp_cnt !== 4'd1) $display("FAIL call1 got out=%h ra=%h sp=%0d want 0200 0101 1", bus.out, bus.ra_top, bus.sp_cnt); else passed++;
    do_cmd(C_CAL, 16'h0300, 0);
    total++; if (bus.out !== 16'h0300 || bus.ra_top !== 16'h0201 || bus.sp_cnt !== 4'd2) $display("FAIL call2 got out=%h ra=%h sp=%0d want 0300 0201 2", bus.out, bus.ra_top, bus.sp_cnt); else passed++;
    do_cmd(C_RET, 0, 0);
    total++; if (bus.out !== 16'h0201 || bus.ra_top !== 16'h0101 || bus.sp_cnt !== 4'd1) $display("FAIL ret1 got out=%h ra=%h sp=%0d want 0201 0101 1", bus.out, bus.ra_top, bus.sp_cnt); else passed++;
    do_cmd(C_RET, 0, 0);
    total++; if (bus.out !== 16'h0101 || bus.empty !== 1'b1 || bus.ra_top !== 16'h0000) $display("FAIL ret2 got out=%h e=%b ra=%h want 0101 1 0000", bus.out, bus.empty, bus.ra_top); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL callret_err got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_bounds();
    logic [15:0] exp_pc;
    do_cmd(C_LD, 16'h0000, 0);
    for (int k = 0; k < 8; k++) begin
      do_cmd(C_CAL, 16'h1000 + 16'(k * 16), 0);
      total++; if (bus.sp_cnt !== 4'(k + 1)) $display("FAIL fill_sp%0d got %0d want %0d", k, bus.sp_cnt, k + 1); else passed++;
    end
    total++; if (bus.full !== 1'b1 || bus.out !== 16'h1070 || bus.ra_top !== 16'h1061) $display("FAIL full got f=%b out=%h ra=%h want 1 1070 1061", bus.full, bus.out, bus.ra_top); else passed++;
    do_cmd(C_CAL, 16'h2000, 0);
    total++; if (bus.out !== 16'h1070 || bus.err !== 1'b1 || bus.sp_cnt !== 4'd8 || bus.ra_top !== 16'h1061) $display("FAIL overflow got out=%h err=%b sp=%0d ra=%h want 1070 1 8 1061", bus.out, bus.err, bus.sp_cnt, bus.ra_top); else passed++;
    for (int j = 0; j < 8; j++) begin
      exp_pc = (j < 7) ? 16'h1001 + 16'((6 - j) * 16) : 16'h0001;
      do_cmd(C_RET, 0, 0);
      total++; if (bus.out !== exp_pc || bus.sp_cnt !== 4'(7 - j)) $display("FAIL pop%0d got out=%h sp=%0d want %h %0d", j, bus.out, bus.sp_cnt, exp_pc, 7 - j); else passed++;
    end
    do_cmd(C_RET, 0, 0);
    total++; if (bus.out !== 16'h0001 || bus.sp_cnt !== 4'd0 || bus.err !== 1'b1 || bus.empty !== 1'b1) $display("FAIL underflow got out=%h sp=%0d err=%b e=%b want 0001 0 1 1", bus.out, bus.sp_cnt, bus.err, bus.empty); else passed++;
    do_cmd(C_CLR, 0, 0);
    total++; if (bus.err !== 1'b0) $display("FAIL clr_err got %b want 0", bus.err); else passed++;
    do_cmd(C_RET | C_CLR, 0, 0);
    total++; if (bus.err !== 1'b1) $display("FAIL clr_vs_set got %b want 1", bus.err); else passed++;
    do_cmd(C_CLR, 0, 0);
    total++; if (bus.err !== 1'b0) $display("FAIL clr_err2 got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_priority();
    do_cmd(C_LD, 16'h0050, 0);
    do_cmd(C_CAL, 16'h0400, 0);
    total++; if (bus.sp_cnt !== 4'd1 || bus.ra_top !== 16'h0051) $display("FAIL prio_setup got sp=%0d ra=%h want 1 0051", bus.sp_cnt, bus.ra_top); else passed++;
    do_cmd(C_RET | C_CAL | C_LD | C_INC, 16'h0777, 0);
    total++; if (bus.out !== 16'h0051 || bus.sp_cnt !== 4'd0 || bus.empty !== 1'b1) $display("FAIL prio_ret got out=%h sp=%0d e=%b want 0051 0 1", bus.out, bus.sp_cnt, bus.empty); else passed++;
    do_cmd(C_LD | C_INC, 16'h00AA, 0);
    total++; if (bus.out !== 16'h00AA) $display("FAIL prio_ld got %h want 00aa", bus.out); else passed++;
    do_cmd(C_REL | C_INC, 0, 16'h0010);
    total++; if (bus.out !== 16'h00BA) $display("FAIL prio_rel got %h want 00ba", bus.out); else passed++;
    do_cmd(C_CAL | C_LD, 16'h0500, 0);
    total++; if (bus.out !== 16'h0500 || bus.ra_top !== 16'h00BB || bus.sp_cnt !== 4'd1) $display("FAIL prio_call got out=%h ra=%h sp=%0d want 0500 00bb 1", bus.out, bus.ra_top, bus.sp_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    do_cmd(C_CAL, 16'h0600, 0);
    do_cmd(C_CAL, 16'h0700, 0);
    do_cmd(C_RET, 0, 0);
    total++; if (bus.out !== 16'h0601 || bus.ra_top !== 16'h0501) $display("FAIL b2b_ret got out=%h ra=%h want 0601 0501", bus.out, bus.ra_top); else passed++;
    do_cmd(C_CAL, 16'h0800, 0);
    total++; if (bus.out !== 16'h0800 || bus.ra_top !== 16'h0602 || bus.sp_cnt !== 4'd3) $display("FAIL b2b_call got out=%h ra=%h sp=%0d want 0800 0602 3", bus.out, bus.ra_top, bus.sp_cnt); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_load_inc();
    test_rel();
    test_call_ret();
    test_bounds();
    test_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
